fpa_f2i: RTL and testbench



---
 rtl/fpa_f2i.sv | 179 +++++++++++++++++
 tb/tb_fpa_f2i.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpa_f2i.sv
// Iterative single-precision float to signed integer converter (truncate toward zero).
// Takes the unpacked sign/exp/mantis fields and shifts the magnitude one bit per cycle.
module fpa_f2i #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [7:0]       exp,
  input  logic [22:0]      mantis,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             invalid,
  output logic             inexact,
  output logic [2:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE, and result/flags
  // stay frozen there until out_ready is seen.

  localparam int MW = (OUT_W > 24) ? OUT_W : 24;
  localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MAX_V = ~MIN_V;
  localparam logic signed [9:0] E_TOP = 10'(OUT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLASS = 3'd1,
    S_SHIFT = 3'd2,
    S_SIGN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [7:0]        exp_q, exp_d;
  logic [22:0]       mantis_q, mantis_d;
  logic [MW-1:0]     mag_q, mag_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              left_q, left_d;
  logic              sticky_q, sticky_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic              invalid_q, invalid_d;
  logic              inexact_q, inexact_d;
  logic              out_valid_q, out_valid_d;

  logic signed [9:0] e_s;
  logic [4:0]        n_w;
  logic [OUT_W-1:0]  mag_lo;

  assign e_s    = $signed({2'b00, exp_q}) - 10'sd127;
  // Only meaningful for the in-range case 0 <= e <= OUT_W-2, where e fits in 5 bits.
  assign n_w    = (e_s > 10'sd23) ? (e_s[4:0] - 5'd23) : (5'd23 - e_s[4:0]);
  assign mag_lo = mag_q[OUT_W-1:0];

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mantis_d  = mantis_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    sticky_d  = sticky_q;
    result_d  = result_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d    = sign;
          exp_d     = exp;
          mantis_d  = mantis;
          result_d  = '0;
          invalid_d = 1'b0;
          inexact_d = 1'b0;
          state_d   = S_CLASS;
        end
      end

      S_CLASS: begin
        state_d = S_DONE;
        if (exp_q == 8'hFF) begin
          invalid_d = 1'b1;
          if (mantis_q != 23'd0) result_d = MIN_V;
          else                   result_d = sign_q ? MIN_V : MAX_V;
        end else if (exp_q == 8'd0) begin
          result_d  = '0;
          inexact_d = (mantis_q != 23'd0);
        end else if (e_s < 10'sd0) begin
          result_d  = '0;
          inexact_d = 1'b1;
        end else if (e_s >= E_TOP) begin
          // -2^(OUT_W-1) is the one representable value at this exponent.
          if (sign_q && (e_s == E_TOP) && (mantis_q == 23'd0)) begin
            result_d = MIN_V;
          end else begin
            result_d  = sign_q ? MIN_V : MAX_V;
            invalid_d = 1'b1;
          end
        end else begin
          mag_d    = MW'({1'b1, mantis_q});
          sticky_d = 1'b0;
          left_d   = (e_s > 10'sd23);
          cnt_d    = n_w;
          state_d  = (n_w != 5'd0) ? S_SHIFT : S_SIGN;
        end
      end

      S_SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[MW-2:0], 1'b0};
        end else begin
          mag_d    = {1'b0, mag_q[MW-1:1]};
          sticky_d = sticky_q | mag_q[0];
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_SIGN;
      end

      S_SIGN: begin
        result_d  = sign_q ? -mag_lo : mag_lo;
        inexact_d = sticky_q;
        state_d   = S_DONE;
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mantis_q    <= '0;
      mag_q       <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      sticky_q    <= 1'b0;
      result_q    <= '0;
      invalid_q   <= 1'b0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mantis_q    <= mantis_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      sticky_q    <= sticky_d;
      result_q    <= result_d;
      invalid_q   <= invalid_d;
      inexact_q   <= inexact_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign invalid   = invalid_q;
  assign inexact   = inexact_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fpa_f2i.sv
// Directed-vector bench for fpa_f2i: value, flags and latency per vector,
// plus backpressure and mid-conversion reset scenarios.
module tb_fpa_f2i;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [7:0]  exp;
  logic [22:0] mantis;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        invalid;
  logic        inexact;
  logic [2:0]  dbg_state;

  int n_vec;
  int n_err;

  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  fpa_f2i #(.OUT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .exp       (exp),
    .mantis    (mantis),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .invalid   (invalid),
    .inexact   (inexact),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: all are entered and left 1 time unit after a rising edge.
  task automatic start_conv(input logic s, input logic [7:0] e, input logic [22:0] m);
    for (int i = 0; i < 200 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    sign     = s;
    exp      = e;
    mantis   = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; returns 100 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic accept_output();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_conv(input logic s, input logic [7:0] e, input logic [22:0] m,
                         output logic [31:0] res, output logic inv, output logic inx,
                         output int lat);
    start_conv(s, e, m);
    wait_done(lat);
    res = result;
    inv = invalid;
    inx = inexact;
    accept_output();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign      = 1'b0;
    exp       = '0;
    mantis    = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    n_vec++;
    if (result !== 32'h0 || invalid !== 1'b0 || inexact !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out result=%h inv=%b inx=%b want 0 0 0", result, invalid, inexact);
    end
    rst_n = 1'b1;
    // out_ready without out_valid must do nothing.
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ready in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic run_table(input vec_t tbl[]);
    logic [31:0] r;
    logic        iv, ix;
    int          lat;
    foreach (tbl[i]) begin
      do_conv(tbl[i].s, tbl[i].e, tbl[i].m, r, iv, ix, lat);
      n_vec++;
      if (r !== tbl[i].res) begin
        n_err++;
        $display("FAIL %s result got %h want %h", tbl[i].name, r, tbl[i].res);
      end
      n_vec++;
      if (iv !== tbl[i].inv || ix !== tbl[i].inx) begin
        n_err++;
        $display("FAIL %s flags got inv=%b inx=%b want inv=%b inx=%b",
                 tbl[i].name, iv, ix, tbl[i].inv, tbl[i].inx);
      end
      n_vec++;
      if (lat !== tbl[i].lat) begin
        n_err++;
        $display("FAIL %s latency got %0d want %0d", tbl[i].name, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_normal();
    vec_t tbl[];
    tbl = new[7];
    tbl[0] = '{"one",       1'b0, 8'd127, 23'h000000, 32'h00000001, 1'b0, 1'b0, 25};
    tbl[1] = '{"neg3p75",   1'b1, 8'd128, 23'h700000, 32'hFFFFFFFD, 1'b0, 1'b1, 24};
    tbl[2] = '{"two_p5",    1'b0, 8'd128, 23'h200000, 32'h00000002, 1'b0, 1'b1, 24};
    tbl[3] = '{"e23",       1'b0, 8'd150, 23'h000001, 32'h00800001, 1'b0, 1'b0, 2};
    tbl[4] = '{"e24_neg",   1'b1, 8'd151, 23'h000001, 32'hFEFFFFFE, 1'b0, 1'b0, 3};
    tbl[5] = '{"max_exact", 1'b0, 8'd157, 23'h7FFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 9};
    tbl[6] = '{"neg_2p30",  1'b1, 8'd157, 23'h000000, 32'hC0000000, 1'b0, 1'b0, 9};
    run_table(tbl);
  endtask

  task automatic test_range();
    vec_t tbl[];
    tbl = new[3];
    tbl[0] = '{"min_exact", 1'b1, 8'd158, 23'h000000, 32'h80000000, 1'b0, 1'b0, 1};
    tbl[1] = '{"pos_ovf",   1'b0, 8'd158, 23'h000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
    tbl[2] = '{"neg_ovf",   1'b1, 8'd158, 23'h000001, 32'h80000000, 1'b1, 1'b0, 1};
    run_table(tbl);
  endtask

  task automatic test_special();
    vec_t tbl[];
    tbl = new[8];
    tbl[0] = '{"nan",     1'b0, 8'd255, 23'h000001, 32'h80000000, 1'b1, 1'b0, 1};
    tbl[1] = '{"ninf",    1'b1, 8'd255, 23'h000000, 32'h80000000, 1'b1, 1'b0, 1};
    tbl[2] = '{"pinf",    1'b0, 8'd255, 23'h000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
    tbl[3] = '{"half",    1'b0, 8'd126, 23'h000000, 32'h00000000, 1'b0, 1'b1, 1};
    tbl[4] = '{"neg_0p75",1'b1, 8'd126, 23'h400000, 32'h00000000, 1'b0, 1'b1, 1};
    tbl[5] = '{"denorm",  1'b0, 8'd0,   23'h000001, 32'h00000000, 1'b0, 1'b1, 1};
    tbl[6] = '{"pzero",   1'b0, 8'd0,   23'h000000, 32'h00000000, 1'b0, 1'b0, 1};
    tbl[7] = '{"nzero",   1'b1, 8'd0,   23'h000000, 32'h00000000, 1'b0, 1'b0, 1};
    run_table(tbl);
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] r;
    logic        iv, ix;
    int          bad;
    start_conv(1'b0, 8'd150, 23'h000001);
    wait_done(lat);
    n_vec++;
    if (lat !== 2 || result !== 32'h00800001) begin
      n_err++;
      $display("FAIL bp_first lat=%0d result=%h want 2 00800001", lat, result);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      sign     = 1'($urandom_range(0, 1));
      exp      = 8'($urandom_range(0, 255));
      mantis   = 23'($urandom_range(0, 32'h7FFFFF));
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h00800001 ||
          invalid !== 1'b0 || inexact !== 1'b0) begin
        n_err++;
        bad++;
        $display("FAIL bp_hold cyc=%0d ov=%b ir=%b res=%h inv=%b inx=%b want 1 0 00800001 0 0",
                 i, out_valid, in_ready, result, invalid, inexact);
      end
    end
    in_valid = 1'b0;
    accept_output();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    do_conv(1'b1, 8'd127, 23'h000000, r, iv, ix, lat);
    n_vec++;
    if (r !== 32'hFFFFFFFF || iv !== 1'b0 || ix !== 1'b0 || lat !== 25) begin
      n_err++;
      $display("FAIL bp_next res=%h inv=%b inx=%b lat=%0d want FFFFFFFF 0 0 25", r, iv, ix, lat);
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [31:0] r;
    logic        iv, ix;
    start_conv(1'b0, 8'd127, 23'h000000);
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (dbg_state !== 3'd2) begin
      n_err++;
      $display("FAIL rst_mid_shift state=%0d want 2", dbg_state);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid out_valid=%b in_ready=%b result=%h want 0 1 0", out_valid, in_ready, result);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_conv(1'b1, 8'd128, 23'h700000, r, iv, ix, lat);
    n_vec++;
    if (r !== 32'hFFFFFFFD || iv !== 1'b0 || ix !== 1'b1 || lat !== 24) begin
      n_err++;
      $display("FAIL rst_after res=%h inv=%b inx=%b lat=%0d want FFFFFFFD 0 1 24", r, iv, ix, lat);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_normal();
    test_range();
    test_special();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
